// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback (WB) versus a buffered multi-cycle unit (AUX).
// WB normally wins; a starvation counter forces the AUX FIFO head out after STARVE_LIMIT consecutive WB wins.
module reg_write_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        wb_valid,
    input  logic [4:0]  wb_id,
    input  logic [31:0] wb_value,
    output logic        wb_stall,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_id,
    input  logic [31:0] aux_value,
    input  logic [4:0]  rs_id,
    input  logic [4:0]  rt_id,
    output logic        hazard,
    output logic        control_reg_write,
    output logic [4:0]  control_write_id,
    output logic [31:0] reg_write_value
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]    fifo_id    [DEPTH];
    logic [31:0]   fifo_value [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [SW-1:0] starve_cnt;

    logic fifo_empty;
    logic force_aux;
    logic wb_req;
    logic pop;
    logic push;

    always_comb begin
        fifo_empty = (count == '0);
        aux_ready  = (count < CW'(DEPTH));
        force_aux  = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
        wb_stall   = force_aux;
        wb_req     = wb_valid && (wb_id != 5'd0) && !force_aux;
        pop        = !fifo_empty && (force_aux || !wb_req);
        push       = aux_valid && aux_ready && (aux_id != 5'd0);
    end

    // Entries already moved to the output register have left the FIFO, so only live slots are scanned.
    logic [PW-1:0] slot_offset;
    always_comb begin
        hazard      = 1'b0;
        slot_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_offset = PW'(i) - rd_ptr;
            if ((CW'(slot_offset) < count) &&
                ((fifo_id[i] == rs_id) || (fifo_id[i] == rt_id)))
                hazard = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_id[wr_ptr]    <= aux_id;
            fifo_value[wr_ptr] <= aux_value;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr            <= '0;
            wr_ptr            <= '0;
            count             <= '0;
            starve_cnt        <= '0;
            control_reg_write <= 1'b0;
            control_write_id  <= 5'd0;
            reg_write_value   <= 32'd0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            // A WB win while AUX waits counts toward starvation; any AUX issue or an empty FIFO resets it.
            if (wb_req && !pop && !fifo_empty) begin
                if (starve_cnt != SW'(STARVE_LIMIT))
                    starve_cnt <= starve_cnt + 1'b1;
            end else if (pop || fifo_empty) begin
                starve_cnt <= '0;
            end

            if (pop) begin
                control_reg_write <= 1'b1;
                control_write_id  <= fifo_id[rd_ptr];
                reg_write_value   <= fifo_value[rd_ptr];
            end else if (wb_req) begin
                control_reg_write <= 1'b1;
                control_write_id  <= wb_id;
                reg_write_value   <= wb_value;
            end else begin
                control_reg_write <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: inputs change 1ns after posedge, outputs sampled in between edges.
module tb_reg_write_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_valid;
    logic [4:0]  wb_id;
    logic [31:0] wb_value;
    logic        wb_stall;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_id;
    logic [31:0] aux_value;
    logic [4:0]  rs_id;
    logic [4:0]  rt_id;
    logic        hazard;
    logic        control_reg_write;
    logic [4:0]  control_write_id;
    logic [31:0] reg_write_value;

    int n_checks = 0;
    int n_fail   = 0;

    reg_write_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .wb_valid          (wb_valid),
        .wb_id             (wb_id),
        .wb_value          (wb_value),
        .wb_stall          (wb_stall),
        .aux_valid         (aux_valid),
        .aux_ready         (aux_ready),
        .aux_id            (aux_id),
        .aux_value         (aux_value),
        .rs_id             (rs_id),
        .rt_id             (rt_id),
        .hazard            (hazard),
        .control_reg_write (control_reg_write),
        .control_write_id  (control_write_id),
        .reg_write_value   (reg_write_value)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic wv, input logic [4:0] wid, input logic [31:0] wval,
                                 input logic av, input logic [4:0] aid, input logic [31:0] aval);
        wb_valid  = wv;
        wb_id     = wid;
        wb_value  = wval;
        aux_valid = av;
        aux_id    = aid;
        aux_value = aval;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkWrite(input string tag, input logic we, input logic [4:0] id, input logic [31:0] val);
        checkOutput({tag, "_we"}, 32'(control_reg_write), 32'(we));
        checkOutput({tag, "_id"}, 32'(control_write_id), 32'(id));
        checkOutput({tag, "_val"}, reg_write_value, val);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        rs_id   = 5'd0;
        rt_id   = 5'd0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkWrite("reset", 0, 0, 0);
        checkOutput("reset_aux_ready", 32'(aux_ready), 1);
        checkOutput("reset_wb_stall", 32'(wb_stall), 0);
        checkOutput("reset_hazard", 32'(hazard), 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // WB alone: written one cycle later, then held while idle
        applyStimulus(1, 5, 32'hA5A5, 0, 0, 0);
        checkOutput("t1_stall", 32'(wb_stall), 0);
        tick();
        checkWrite("t1_wb", 1, 5, 32'hA5A5);
        checkOutput("t1_aux_ready", 32'(aux_ready), 1);
        checkOutput("t1_hazard", 32'(hazard), 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("t1_idle", 0, 5, 32'hA5A5);

        // WB and AUX in the same cycle: WB first, AUX next
        applyStimulus(1, 3, 32'h11, 1, 4, 32'h22);
        checkOutput("t2_ready", 32'(aux_ready), 1);
        tick();
        checkWrite("t2_wb", 1, 3, 32'h11);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rs_id = 5'd4;
        #1;
        checkOutput("t2_hazard_q", 32'(hazard), 1);
        tick();
        checkWrite("t2_aux", 1, 4, 32'h22);
        checkOutput("t2_hazard_done", 32'(hazard), 0);
        rs_id = 5'd0;
        tick();
        checkWrite("t2_idle", 0, 4, 32'h22);
        checkOutput("t2_empty_ready", 32'(aux_ready), 1);

        // Starvation: r7 queued behind a continuous WB stream
        applyStimulus(1, 1, 32'h100, 1, 7, 32'h77);
        tick();
        checkWrite("t3_first", 1, 1, 32'h100);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 5'(10 + k), 32'(k + 1), 0, 0, 0);
            checkOutput($sformatf("t3_nostall%0d", k), 32'(wb_stall), 0);
            tick();
            checkWrite($sformatf("t3_wb%0d", k), 1, 5'(10 + k), 32'(k + 1));
        end
        applyStimulus(1, 20, 32'h200, 0, 0, 0);
        checkOutput("t3_stall", 32'(wb_stall), 1);
        tick();
        checkWrite("t3_forced", 1, 7, 32'h77);
        checkOutput("t3_unstall", 32'(wb_stall), 0);
        tick();
        checkWrite("t3_held_wb", 1, 20, 32'h200);

        // Full FIFO, forced drain and pointer wrap
        applyStimulus(1, 1, 32'h1, 1, 21, 32'h21);
        checkOutput("t4_ready_a", 32'(aux_ready), 1);
        tick();
        applyStimulus(1, 2, 32'h2, 1, 22, 32'h22);
        checkOutput("t4_ready_b", 32'(aux_ready), 1);
        tick();
        applyStimulus(1, 3, 32'h3, 1, 23, 32'h23);
        checkOutput("t4_full", 32'(aux_ready), 0);
        tick();
        applyStimulus(1, 4, 32'h4, 1, 23, 32'h23);
        tick();
        applyStimulus(1, 5, 32'h5, 1, 23, 32'h23);
        checkOutput("t4_prestall", 32'(wb_stall), 0);
        tick();
        checkWrite("t4_wb5", 1, 5, 32'h5);
        applyStimulus(1, 6, 32'h6, 1, 23, 32'h23);
        checkOutput("t4_stall", 32'(wb_stall), 1);
        checkOutput("t4_full_pop", 32'(aux_ready), 0);
        tick();
        checkWrite("t4_pop21", 1, 21, 32'h21);
        checkOutput("t4_ready_after", 32'(aux_ready), 1);
        tick();
        checkWrite("t4_wb6", 1, 6, 32'h6);
        applyStimulus(0, 0, 0, 1, 24, 32'h24);
        checkOutput("t4_full2", 32'(aux_ready), 0);
        tick();
        checkWrite("t4_pop22", 1, 22, 32'h22);
        tick();
        checkWrite("t4_pop23", 1, 23, 32'h23);
        applyStimulus(0, 0, 0, 1, 25, 32'h25);
        tick();
        checkWrite("t4_pop24", 1, 24, 32'h24);
        applyStimulus(0, 0, 0, 0, 0, 0);
        tick();
        checkWrite("t4_pop25", 1, 25, 32'h25);
        tick();
        checkWrite("t4_idle", 0, 25, 32'h25);

        // Hazard against a queued r9, and id 0 AUX writes dropped
        applyStimulus(1, 1, 32'h1, 1, 9, 32'h99);
        tick();
        applyStimulus(1, 2, 32'h2, 0, 0, 0);
        rs_id = 5'd9;
        #1;
        checkOutput("t5_rs", 32'(hazard), 1);
        rs_id = 5'd0;
        #1;
        checkOutput("t5_none", 32'(hazard), 0);
        rt_id = 5'd9;
        #1;
        checkOutput("t5_rt", 32'(hazard), 1);
        rt_id = 5'd0;
        rs_id = 5'd9;
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_still", 32'(hazard), 1);
        tick();
        checkWrite("t5_r9", 1, 9, 32'h99);
        checkOutput("t5_cleared", 32'(hazard), 0);
        rs_id = 5'd0;
        applyStimulus(0, 0, 0, 1, 0, 32'hDEAD);
        checkOutput("t5_zero_ready", 32'(aux_ready), 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("t5_zero_hazard", 32'(hazard), 0);
        tick();
        checkWrite("t5_zero_dropped", 0, 9, 32'h99);

        // Asynchronous reset with two entries queued
        applyStimulus(1, 1, 32'h1, 1, 11, 32'hB);
        tick();
        applyStimulus(1, 2, 32'h2, 1, 12, 32'hC);
        tick();
        checkWrite("t6_pre", 1, 2, 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0);
        rs_id = 5'd11;
        #2;
        reset_n = 1'b0;
        #1;
        checkWrite("t6_reset", 0, 0, 0);
        checkOutput("t6_ready", 32'(aux_ready), 1);
        checkOutput("t6_hazard", 32'(hazard), 0);
        checkOutput("t6_stall", 32'(wb_stall), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();
        checkWrite("t6_quiet1", 0, 0, 0);
        tick();
        checkWrite("t6_quiet2", 0, 0, 0);
        checkOutput("t6_hazard_after", 32'(hazard), 0);
        applyStimulus(1, 30, 32'h3030, 0, 0, 0);
        tick();
        checkWrite("t6_new", 1, 30, 32'h3030);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
